wb_slave_router: RTL and testbench

//  Parametrised Wishbone address router for the user project area. Connects one

---
 rtl/wb_slave_router.sv | 177 +++++++++++++++++
 tb/tb_wb_slave_router.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_router.sv
// rtl/wb_slave_router.sv - Wishbone base/mask address router with timeout and sticky error log
module wb_slave_router #(
    parameter int                  N_SLV      = 5,
    parameter logic [N_SLV*32-1:0] BASE_ADDRS = {32'h30000300, 32'h30000200, 32'h30000100,
                                                 32'h30000000, 32'h38000000},
    parameter logic [N_SLV*32-1:0] ADDR_MASKS = {{4{32'hFF000F00}}, 32'hFF000000},
    parameter int                  TIMEOUT    = 255,
    parameter logic [31:0]         ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_dat_i,
    input  logic [31:0]         wbs_adr_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    output logic [N_SLV-1:0]    slv_valid_o,
    output logic                slv_we_o,
    output logic [3:0]          slv_sel_o,
    output logic [31:0]         slv_dat_o,
    output logic [31:0]         slv_adr_o,
    input  logic [N_SLV-1:0]    slv_ack_i,
    input  logic [N_SLV*32-1:0] slv_dat_i,
    output logic                err_irq_o,
    input  logic                err_clr_i,
    output logic [7:0]          err_cnt_o,
    output logic [31:0]         err_adr_o
);

    localparam int IW = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   cur_idx;
    logic [TW-1:0]   timer;
    logic [31:0]     adr_q;

    logic            req;
    logic [N_SLV-1:0] hit;
    logic            any_hit;
    logic [IW-1:0]   dec_idx;
    logic            timeout_hit;
    logic            log_err;

    assign req         = wbs_cyc_i & wbs_stb_i;
    assign timeout_hit = (timer == TW'(TIMEOUT));

    // Master signals are broadcast to every slave; only the valid is routed
    assign slv_we_o  = wbs_we_i  & ~wb_rst_i;
    assign slv_sel_o = wbs_sel_i & {4{~wb_rst_i}};
    assign slv_dat_o = wbs_dat_i & {32{~wb_rst_i}};
    assign slv_adr_o = wbs_adr_i & {32{~wb_rst_i}};

    // Address decode: lowest-index matching window wins
    always_comb begin
        hit     = '0;
        dec_idx = '0;
        for (int i = 0; i < N_SLV; i++) begin
            hit[i] = ((wbs_adr_i & ADDR_MASKS[i*32 +: 32]) ==
                      (BASE_ADDRS[i*32 +: 32] & ADDR_MASKS[i*32 +: 32]));
        end
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (hit[i]) dec_idx = IW'(i);
        end
        any_hit = |hit;
    end

    // Response path: same-cycle routing in IDLE, tracked slave in BUSY, error word otherwise
    always_comb begin
        wbs_ack_o   = 1'b0;
        wbs_dat_o   = '0;
        slv_valid_o = '0;
        log_err     = 1'b0;
        if (!wb_rst_i) begin
            case (state)
                ST_IDLE: begin
                    if (req && any_hit) begin
                        slv_valid_o[dec_idx] = 1'b1;
                        if (slv_ack_i[dec_idx]) begin
                            wbs_ack_o = 1'b1;
                            wbs_dat_o = slv_dat_i[dec_idx*32 +: 32];
                        end
                    end
                end
                ST_BUSY: begin
                    if (req) begin
                        if (slv_ack_i[cur_idx]) begin
                            slv_valid_o[cur_idx] = 1'b1;
                            wbs_ack_o            = 1'b1;
                            wbs_dat_o            = slv_dat_i[cur_idx*32 +: 32];
                        end else if (timeout_hit) begin
                            wbs_ack_o = 1'b1;
                            wbs_dat_o = ERR_DATA;
                            log_err   = 1'b1;
                        end else begin
                            slv_valid_o[cur_idx] = 1'b1;
                        end
                    end
                end
                ST_ERR: begin
                    wbs_ack_o = 1'b1;
                    wbs_dat_o = ERR_DATA;
                    log_err   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Transaction tracker: remembers target and address, counts BUSY cycles
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state   <= ST_IDLE;
            cur_idx <= '0;
            timer   <= '0;
            adr_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        adr_q <= wbs_adr_i;
                        if (any_hit) begin
                            cur_idx <= dec_idx;
                            if (!slv_ack_i[dec_idx]) begin
                                state <= ST_BUSY;
                                timer <= '0;
                            end
                        end else begin
                            state <= ST_ERR;
                        end
                    end
                end
                ST_BUSY: begin
                    if (!req || slv_ack_i[cur_idx] || timeout_hit) begin
                        state <= ST_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_ERR: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky error log; a new error in the same cycle as a clear takes priority
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            err_irq_o <= 1'b0;
            err_cnt_o <= '0;
            err_adr_o <= '0;
        end else if (log_err) begin
            err_irq_o <= 1'b1;
            err_adr_o <= adr_q;
            if (err_clr_i)
                err_cnt_o <= 8'd1;
            else if (err_cnt_o != 8'hFF)
                err_cnt_o <= err_cnt_o + 8'd1;
        end else if (err_clr_i) begin
            err_irq_o <= 1'b0;
            err_cnt_o <= '0;
            err_adr_o <= '0;
        end
    end

endmodule

// File: tb/tb_wb_slave_router.sv
// tb/tb_wb_slave_router.sv - table-driven and randomized bench for wb_slave_router
module tb_wb_slave_router;

    localparam int          N  = 5;
    localparam int          TO = 15;
    localparam logic [31:0] ED = 32'hDEAD_BEEF;
    localparam int          NEVER = 1000;

    logic           clk = 1'b0;
    logic           rst;
    logic           cyc, stb, we, err_clr;
    logic [3:0]     sel;
    logic [31:0]    wdat, wadr;
    logic           ack_o;
    logic [31:0]    dat_o;
    logic [N-1:0]   valid_o;
    logic           slv_we;
    logic [3:0]     slv_sel;
    logic [31:0]    slv_dat, slv_adr;
    logic [N-1:0]   acks;
    logic [N*32-1:0] sdat;
    logic           irq;
    logic [7:0]     cnt;
    logic [31:0]    eadr;

    wb_slave_router #(.TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_dat_i(wdat), .wbs_adr_i(wadr),
        .wbs_ack_o(ack_o), .wbs_dat_o(dat_o),
        .slv_valid_o(valid_o), .slv_we_o(slv_we), .slv_sel_o(slv_sel),
        .slv_dat_o(slv_dat), .slv_adr_o(slv_adr),
        .slv_ack_i(acks), .slv_dat_i(sdat),
        .err_irq_o(irq), .err_clr_i(err_clr), .err_cnt_o(cnt), .err_adr_o(eadr)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Address map as the firmware sees it: slave i -> (base, mask)
    logic [31:0] base_m [N] = '{32'h38000000, 32'h30000000, 32'h30000100, 32'h30000200, 32'h30000300};
    logic [31:0] mask_m [N] = '{32'hFF000000, 32'hFF000F00, 32'hFF000F00, 32'hFF000F00, 32'hFF000F00};

    bit          irq_m;
    int          cnt_m;
    logic [31:0] adr_m;

    typedef struct {
        logic [31:0] adr;
        int          lat;
        logic [4:0]  noise;
        logic [31:0] d;
        int          exp_idx;
        int          exp_ack;
        logic [31:0] exp_dat;
        bit          exp_err;
    } vec_t;

    vec_t tbl [8];

    function automatic int model_idx(input logic [31:0] a);
        for (int i = 0; i < N; i++)
            if ((a & mask_m[i]) == (base_m[i] & mask_m[i])) return i;
        return -1;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        cyc = 0; stb = 0; acks = '0; err_clr = 0;
    endtask

    task automatic check_log(input string name);
        check(name, {23'h0, irq, cnt, eadr}, {23'h0, irq_m, 8'(cnt_m), adr_m});
    endtask

    // One complete transaction; cycle 0 is the request cycle
    task automatic run_txn(input logic [31:0] adr, input bit wr, input int lat, input logic [4:0] noise,
                           input logic [31:0] d, input int exp_idx, input int exp_ack,
                           input logic [31:0] exp_dat, input bit exp_err, input int clr_at);
        logic [N-1:0] ev;
        for (int c = 0; c <= exp_ack; c++) begin
            cyc = 1; stb = 1; we = wr; wadr = adr;
            sel = 4'($urandom); wdat = $urandom;
            acks = noise;
            if (exp_idx >= 0) acks[exp_idx] = (c == lat);
            for (int i = 0; i < N; i++) sdat[i*32 +: 32] = (i == exp_idx) ? d : ~d;
            err_clr = (c == clr_at);
            @(negedge clk);
            ev = '0;
            if (exp_idx >= 0 && (c < exp_ack || (c == exp_ack && !exp_err))) ev[exp_idx] = 1'b1;
            check("txn", {26'h0, ack_o, valid_o, dat_o},
                  {26'h0, c == exp_ack, ev, (c == exp_ack) ? exp_dat : 32'h0});
            if (c == 0) begin
                check("bcast_adr_dat", {slv_adr, slv_dat}, {adr, wdat});
                check("bcast_we_sel", {59'h0, slv_we, slv_sel}, {59'h0, wr, sel});
            end
            tick();
        end
        if (exp_err) begin
            if (clr_at == exp_ack) cnt_m = 0;
            irq_m = 1;
            if (cnt_m < 255) cnt_m++;
            adr_m = adr;
        end
        drive_idle();
        @(negedge clk);
        check_log("errlog");
        tick();
    endtask

    task automatic run_model(input logic [31:0] adr, input int lat, input logic [4:0] noise,
                             input logic [31:0] d, input int clr_at);
        int idx;
        idx = model_idx(adr);
        if (idx < 0)
            run_txn(adr, $urandom_range(0, 1), lat, noise, d, -1, 1, ED, 1, clr_at);
        else if (lat <= TO + 1)
            run_txn(adr, $urandom_range(0, 1), lat, noise, d, idx, lat, d, 0, clr_at);
        else
            run_txn(adr, $urandom_range(0, 1), lat, noise, d, idx, TO + 1, ED, 1, clr_at);
    endtask

    initial begin
        logic [31:0] a;
        int lat;

        tbl[0] = '{32'h30000100, 3,     5'b00000, 32'h00001234, 2,  3,  32'h00001234, 1'b0};
        tbl[1] = '{32'h38000010, 0,     5'b00000, 32'hCAFE0001, 0,  0,  32'hCAFE0001, 1'b0};
        tbl[2] = '{32'h30000500, 0,     5'b00000, 32'h11111111, -1, 1,  ED,           1'b1};
        tbl[3] = '{32'h30000200, NEVER, 5'b00000, 32'h22222222, 3,  16, ED,           1'b1};
        tbl[4] = '{32'h30000300, 16,    5'b00000, 32'h33333333, 4,  16, 32'h33333333, 1'b0};
        tbl[5] = '{32'h30000000, 1,     5'b00100, 32'h44444444, 1,  1,  32'h44444444, 1'b0};
        tbl[6] = '{32'h38FFFFFF, 2,     5'b11110, 32'h55555555, 0,  2,  32'h55555555, 1'b0};
        tbl[7] = '{32'h30ABC000, 0,     5'b00000, 32'h66666666, 1,  0,  32'h66666666, 1'b0};

        rst = 1; drive_idle(); we = 0; sel = 0; wdat = 0; wadr = 0; sdat = '0;
        irq_m = 0; cnt_m = 0; adr_m = 0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_out", {26'h0, ack_o, valid_o, dat_o}, 64'h0);
        check_log("reset_log");
        tick();
        rst = 0;
        tick();

        for (int k = 0; k < 8; k++)
            run_txn(tbl[k].adr, k[0], tbl[k].lat, tbl[k].noise, tbl[k].d, tbl[k].exp_idx,
                    tbl[k].exp_ack, tbl[k].exp_dat, tbl[k].exp_err, -1);

        // Back-to-back single-cycle writes to slave0
        for (int k = 0; k < 3; k++) begin
            cyc = 1; stb = 1; we = 1; wadr = 32'h38000000 + 32'(k * 4);
            acks = 5'b00001;
            for (int i = 0; i < N; i++) sdat[i*32 +: 32] = 32'hB0B00000 + 32'(k);
            @(negedge clk);
            check("b2b", {26'h0, ack_o, valid_o, dat_o}, {26'h0, 1'b1, 5'b00001, 32'hB0B00000 + 32'(k)});
            tick();
        end
        drive_idle();
        tick();

        // Foreign acks ignored, then master abort in BUSY
        for (int c = 0; c < 4; c++) begin
            cyc = (c < 3); stb = (c < 3); we = 0; wadr = 32'h30000100;
            acks = 5'b00010;
            for (int i = 0; i < N; i++) sdat[i*32 +: 32] = (i == 2) ? 32'h55 : 32'h66;
            @(negedge clk);
            check("abort", {26'h0, ack_o, valid_o, dat_o}, {26'h0, 1'b0, (c < 3) ? 5'b00100 : 5'b00000, 32'h0});
            tick();
        end
        drive_idle();
        @(negedge clk);
        check_log("abort_log");
        tick();
        run_txn(32'h38000000, 0, 0, 5'b00000, 32'h77, 0, 0, 32'h77, 0, -1);

        // Reset while BUSY
        for (int c = 0; c < 3; c++) begin
            cyc = 1; stb = 1; wadr = 32'h30000200; acks = '0;
            @(negedge clk);
            check("pre_reset", {26'h0, ack_o, valid_o, dat_o}, {26'h0, 1'b0, 5'b01000, 32'h0});
            tick();
        end
        acks = 5'b01000;
        rst = 1;
        #1;
        check("reset_busy", {26'h0, ack_o, valid_o, dat_o}, 64'h0);
        check("reset_bcast", {27'h0, slv_we, slv_sel, slv_adr}, 64'h0);
        irq_m = 0; cnt_m = 0; adr_m = 0;
        check_log("reset_busy_log");
        tick();
        rst = 0; drive_idle();
        tick();
        run_txn(32'h30000300, 1, 0, 5'b00000, 32'h88, 4, 0, 32'h88, 0, -1);

        // Clear alone, then clear coincident with an error
        run_txn(32'h31000000, 0, 0, 5'b00000, 32'h0, -1, 1, ED, 1, -1);
        err_clr = 1;
        tick();
        err_clr = 0;
        irq_m = 0; cnt_m = 0; adr_m = 0;
        @(negedge clk);
        check_log("clr_log");
        tick();
        run_txn(32'h30000600, 0, 0, 5'b00000, 32'h0, -1, 1, ED, 1, -1);
        run_txn(32'h30000700, 0, 0, 5'b00000, 32'h0, -1, 1, ED, 1, 1);
        check("clr_vs_err_cnt", 64'(cnt), 64'd1);

        // Randomized traffic against the map model
        for (int k = 0; k < 150; k++) begin
            a = $urandom;
            case ($urandom_range(0, 2))
                0: a[31:24] = 8'h30;
                1: a[31:24] = 8'h38;
                default: ;
            endcase
            a[11:8] = 4'($urandom_range(0, 6));
            lat = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 5);
            run_model(a, lat, 5'($urandom), $urandom, -1);
        end

        // Counter saturation
        for (int k = 0; k < 260; k++)
            run_model(32'h30000F00, 0, 5'b00000, 32'h0, -1);
        check("sat_cnt", 64'(cnt), 64'd255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
